// File: rtl/csr_access_if.sv
// Request/response channel between execute and the CSR access unit.
interface csr_access_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned F3W  = 3;
    localparam int unsigned IDXW = 12;
    localparam int unsigned REGW = 5;

    logic            req_valid;
    logic            req_ready;
    logic [F3W-1:0]  req_funct3;
    logic [IDXW-1:0] req_csr_idx;
    logic [REGW-1:0] req_rs1_idx;
    logic [XLEN-1:0] req_rs1_data;
    logic [REGW-1:0] req_rd_idx;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic [REGW-1:0] rsp_rd_idx;
    logic            rsp_illegal;

    modport master (
        output req_valid, req_funct3, req_csr_idx, req_rs1_idx, req_rs1_data, req_rd_idx,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_rd_idx, rsp_illegal
    );

    modport slave (
        input  req_valid, req_funct3, req_csr_idx, req_rs1_idx, req_rs1_data, req_rd_idx,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_rd_idx, rsp_illegal
    );
endinterface

// File: rtl/csr_access_unit.sv
// Read-modify-write sequencer for CSR instructions in front of cs_reg_file.
// Optional macro CSR_RO_CHECK_EN: flag writes to read-only CSR space (idx[11:10]==2'b11) as illegal.
module csr_access_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    csr_access_if.slave     bus_io,
    output logic            csr_rd_en_o,
    output logic            csr_wr_en_o,
    output logic [11:0]     csr_idx_o,
    output logic [XLEN-1:0] csr_wdata_o,
    input  logic [XLEN-1:0] csr_rdata_i
);
    localparam int unsigned F3W  = 3;
    localparam int unsigned IDXW = 12;
    localparam int unsigned REGW = 5;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

    state_e          state_q, state_d;
    logic [F3W-1:0]  funct3_q, funct3_d;
    logic [REGW-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [REGW-1:0] rd_q, rd_d;
    logic [XLEN-1:0] old_q, old_d;

    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [REGW-1:0] rsp_rd_idx_q, rsp_rd_idx_d;
    logic            rsp_illegal_q, rsp_illegal_d;
    logic            csr_rd_en_q, csr_rd_en_d;
    logic            csr_wr_en_q, csr_wr_en_d;
    logic [IDXW-1:0] csr_idx_q, csr_idx_d;
    logic [XLEN-1:0] csr_wdata_q, csr_wdata_d;

    logic [XLEN-1:0] old_val, src_val, new_val;
    logic            ro_fault, illegal;

    function automatic logic f_illegal(input logic [F3W-1:0] f3);
        return f3[1:0] == 2'b00;
    endfunction

    // CSRRW/CSRRWI to x0 must not cause read side effects
    function automatic logic f_do_read(input logic [F3W-1:0] f3, input logic [REGW-1:0] rd);
        return !(f3[1:0] == 2'b01 && rd == REGW'(0));
    endfunction

    function automatic logic f_do_write(input logic [F3W-1:0] f3, input logic [REGW-1:0] rs1);
        return (f3[1:0] == 2'b01) || (rs1 != REGW'(0));
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            funct3_q      <= '0;
            rs1_q         <= '0;
            rs1_data_q    <= '0;
            rd_q          <= '0;
            old_q         <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_rd_idx_q  <= '0;
            rsp_illegal_q <= 1'b0;
            csr_rd_en_q   <= 1'b0;
            csr_wr_en_q   <= 1'b0;
            csr_idx_q     <= '0;
            csr_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            funct3_q      <= funct3_d;
            rs1_q         <= rs1_d;
            rs1_data_q    <= rs1_data_d;
            rd_q          <= rd_d;
            old_q         <= old_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_rd_idx_q  <= rsp_rd_idx_d;
            rsp_illegal_q <= rsp_illegal_d;
            csr_rd_en_q   <= csr_rd_en_d;
            csr_wr_en_q   <= csr_wr_en_d;
            csr_idx_q     <= csr_idx_d;
            csr_wdata_q   <= csr_wdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        funct3_d      = funct3_q;
        rs1_d         = rs1_q;
        rs1_data_d    = rs1_data_q;
        rd_d          = rd_q;
        old_d         = old_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_rd_idx_d  = rsp_rd_idx_q;
        rsp_illegal_d = rsp_illegal_q;
        csr_rd_en_d   = csr_rd_en_q;
        csr_wr_en_d   = csr_wr_en_q;
        csr_idx_d     = csr_idx_q;
        csr_wdata_d   = csr_wdata_q;

        // Old value is only meaningful in READ, where rd_en and idx are presented
        old_val = csr_rd_en_q ? csr_rdata_i : '0;
        src_val = funct3_q[2] ? XLEN'(rs1_q) : rs1_data_q;
        case (funct3_q[1:0])
            2'b10:   new_val = old_val | src_val;
            2'b11:   new_val = old_val & ~src_val;
            default: new_val = src_val;
        endcase

        ro_fault = 1'b0;
`ifdef CSR_RO_CHECK_EN
        ro_fault = f_do_write(funct3_q, rs1_q) && (csr_idx_q[11:10] == 2'b11);
`endif
        illegal = f_illegal(funct3_q) || ro_fault;

        case (state_q)
            IDLE: begin
                if (bus_io.req_valid && req_ready_q) begin
                    funct3_d    = bus_io.req_funct3;
                    rs1_d       = bus_io.req_rs1_idx;
                    rs1_data_d  = bus_io.req_rs1_data;
                    rd_d        = bus_io.req_rd_idx;
                    csr_idx_d   = bus_io.req_csr_idx;
                    csr_rd_en_d = f_do_read(bus_io.req_funct3, bus_io.req_rd_idx)
                                  && !f_illegal(bus_io.req_funct3);
                    req_ready_d = 1'b0;
                    state_d     = READ;
                end
            end
            READ: begin
                old_d       = old_val;
                csr_rd_en_d = 1'b0;
                if (f_do_write(funct3_q, rs1_q) && !illegal) begin
                    csr_wr_en_d = 1'b1;
                    csr_wdata_d = new_val;
                    state_d     = WRITE;
                end else begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = illegal ? '0 : old_val;
                    rsp_rd_idx_d  = rd_q;
                    rsp_illegal_d = illegal;
                    state_d       = RESP;
                end
            end
            WRITE: begin
                csr_wr_en_d   = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = old_q;
                rsp_rd_idx_d  = rd_q;
                rsp_illegal_d = 1'b0;
                state_d       = RESP;
            end
            RESP: begin
                if (bus_io.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_io.req_ready   = req_ready_q;
    assign bus_io.rsp_valid   = rsp_valid_q;
    assign bus_io.rsp_rdata   = rsp_rdata_q;
    assign bus_io.rsp_rd_idx  = rsp_rd_idx_q;
    assign bus_io.rsp_illegal = rsp_illegal_q;
    assign csr_rd_en_o        = csr_rd_en_q;
    assign csr_wr_en_o        = csr_wr_en_q;
    assign csr_idx_o          = csr_idx_q;
    assign csr_wdata_o        = csr_wdata_q;
endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit with a behavioural CSR file and reference model.
module tb_csr_access_unit;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        csr_rd_en, csr_wr_en;
    logic [11:0] csr_idx;
    logic [31:0] csr_wdata, csr_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    csr_access_if #(.XLEN(32)) bus ();

    csr_access_unit #(.XLEN(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus_io      (bus),
        .csr_rd_en_o (csr_rd_en),
        .csr_wr_en_o (csr_wr_en),
        .csr_idx_o   (csr_idx),
        .csr_wdata_o (csr_wdata),
        .csr_rdata_i (csr_rdata)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural cs_reg_file: combinational read, writes to read-only space are dropped
    logic [31:0] rf [4096];
    logic        clear_rf;
    int          rd_cnt = 0, wr_cnt = 0;
    logic [31:0] last_wdata;
    logic [11:0] last_widx;
    assign csr_rdata = rf[csr_idx];

    always @(posedge clk_i) begin
        if (clear_rf) begin
            for (int i = 0; i < 4096; i++) rf[i] = 32'h0;
        end else begin
            if (csr_rd_en) rd_cnt = rd_cnt + 1;
            if (csr_wr_en) begin
                wr_cnt     = wr_cnt + 1;
                last_wdata = csr_wdata;
                last_widx  = csr_idx;
                if (csr_idx[11:10] != 2'b11) rf[csr_idx] = csr_wdata;
            end
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] idx;
        logic [4:0]  rs1;
        logic [31:0] data;
        logic [4:0]  rd;
    } req_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic [4:0]  rd_idx;
        logic        illegal;
        int          rd_n;
        int          wr_n;
        logic [31:0] wdata;
        logic [11:0] widx;
        logic        hold_ok;
        logic        idle_after;
    } obs_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        illegal;
        int          rd_n;
        int          wr_n;
        logic [31:0] wdata;
    } exp_t;

    logic [31:0] ref_mem [4096];

    // Reference: architectural CSR semantics applied to the model's own CSR contents
    task automatic model(input req_t r, output exp_t e);
        logic [31:0] old, src, nv;
        logic        bad_f3, rd_ok, wr_try, ro_bad;
        old    = ref_mem[r.idx];
        src    = r.f3[2] ? {27'b0, r.rs1} : r.data;
        bad_f3 = (r.f3 == 3'd0) || (r.f3 == 3'd4);
        rd_ok  = !bad_f3 && !((r.f3 == 3'd1 || r.f3 == 3'd5) && r.rd == 5'd0);
        wr_try = !bad_f3 && ((r.f3 == 3'd1 || r.f3 == 3'd5) || r.rs1 != 5'd0);
        ro_bad = 1'b0;
`ifdef CSR_RO_CHECK_EN
        ro_bad = wr_try && (r.idx >= 12'hC00);
`endif
        if (r.f3 == 3'd1 || r.f3 == 3'd5)      nv = src;
        else if (r.f3 == 3'd2 || r.f3 == 3'd6) nv = old | src;
        else                                   nv = old & ~src;
        e.illegal = bad_f3 || ro_bad;
        e.rd_n    = rd_ok ? 1 : 0;
        e.wr_n    = (wr_try && !ro_bad) ? 1 : 0;
        e.wdata   = nv;
        e.lat     = (e.wr_n == 1) ? 3 : 2;
        e.rdata   = (e.illegal || !rd_ok) ? 32'h0 : old;
        if (e.wr_n == 1 && r.idx < 12'hC00) ref_mem[r.idx] = nv;
    endtask

    task automatic run_txn(input req_t r, input int hold, output obs_t o);
        int rd0, wr0;
        logic acc;
        logic [31:0] s_rdata;
        logic [4:0]  s_rd;
        logic        s_ill;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        bus.req_funct3   = r.f3;
        bus.req_csr_idx  = r.idx;
        bus.req_rs1_idx  = r.rs1;
        bus.req_rs1_data = r.data;
        bus.req_rd_idx   = r.rd;
        bus.req_valid    = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            acc = bus.req_ready;
            @(posedge clk_i); #1;
        end
        bus.req_valid = 1'b0;
        o.lat = 1;
        while (!bus.rsp_valid && o.lat < 10) begin
            @(posedge clk_i); #1;
            o.lat++;
        end
        if (!acc || !bus.rsp_valid) o.lat = 99;
        o.rdata   = bus.rsp_rdata;
        o.rd_idx  = bus.rsp_rd_idx;
        o.illegal = bus.rsp_illegal;
        s_rdata = bus.rsp_rdata; s_rd = bus.rsp_rd_idx; s_ill = bus.rsp_illegal;
        o.hold_ok = 1'b1;
        repeat (hold) begin
            @(posedge clk_i); #1;
            if (bus.rsp_rdata !== s_rdata || bus.rsp_rd_idx !== s_rd || bus.rsp_illegal !== s_ill ||
                bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) o.hold_ok = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk_i); #1;
        bus.rsp_ready = 1'b0;
        o.idle_after = (bus.req_ready === 1'b1) && (bus.rsp_valid === 1'b0);
        o.rd_n  = rd_cnt - rd0;
        o.wr_n  = wr_cnt - wr0;
        o.wdata = last_wdata;
        o.widx  = last_widx;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (csr_rd_en !== 1'b0 || csr_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got rd %b wr %b want 0 0", csr_rd_en, csr_wr_en); end
        n_checks++; if (csr_idx !== 12'h0 || csr_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_csr_bus: got idx %h wdata %h want 0 0", csr_idx, csr_wdata); end
        n_checks++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_rd_idx !== 5'h0 || bus.rsp_illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp_fields: got %h %h %b want 0 0 0", bus.rsp_rdata, bus.rsp_rd_idx, bus.rsp_illegal); end
    endtask

    task automatic test_csrrw();
        req_t r; obs_t o; exp_t e;
        r = '{f3: 3'd1, idx: 12'h340, rs1: 5'd2, data: 32'hDEADBEEF, rd: 5'd5};
        model(r, e);
        run_txn(r, 0, o);
        n_checks++; if (o.wr_n !== 1 || o.wdata !== 32'hDEADBEEF || o.widx !== 12'h340) begin
            n_fail++; $display("FAIL csrrw_write: got n=%0d wdata %h idx %h want 1 deadbeef 340", o.wr_n, o.wdata, o.widx); end
        n_checks++; if (o.rdata !== 32'h0 || o.rd_idx !== 5'd5) begin
            n_fail++; $display("FAIL csrrw_rsp: got rdata %h rd %0d want 0 5", o.rdata, o.rd_idx); end
        n_checks++; if (o.lat !== 3) begin n_fail++; $display("FAIL csrrw_latency: got %0d want 3", o.lat); end
        n_checks++; if (!o.idle_after) begin n_fail++; $display("FAIL csrrw_idle_after: got 0 want 1"); end
    endtask

    task automatic test_set_clear();
        req_t r; obs_t o; exp_t e;
        r = '{f3: 3'd1, idx: 12'h305, rs1: 5'd1, data: 32'h000000F0, rd: 5'd0};
        model(r, e); run_txn(r, 0, o);
        n_checks++; if (o.rd_n !== 0) begin n_fail++; $display("FAIL rw_x0_no_read: got %0d reads want 0", o.rd_n); end
        r = '{f3: 3'd2, idx: 12'h305, rs1: 5'd3, data: 32'h0000000F, rd: 5'd7};
        model(r, e); run_txn(r, 0, o);
        n_checks++; if (o.wdata !== 32'h000000FF || o.rdata !== 32'h000000F0) begin
            n_fail++; $display("FAIL csrrs: got wdata %h rdata %h want ff f0", o.wdata, o.rdata); end
        r = '{f3: 3'd3, idx: 12'h305, rs1: 5'd4, data: 32'h000000F0, rd: 5'd8};
        model(r, e); run_txn(r, 0, o);
        n_checks++; if (o.wdata !== 32'h0000000F || o.rdata !== 32'h000000FF || o.wr_n !== 1) begin
            n_fail++; $display("FAIL csrrc: got wdata %h rdata %h n=%0d want 0f ff 1", o.wdata, o.rdata, o.wr_n); end
    endtask

    task automatic test_immediate();
        req_t r; obs_t o; exp_t e;
        r = '{f3: 3'd6, idx: 12'h300, rs1: 5'd0, data: 32'hFFFFFFFF, rd: 5'd9};
        model(r, e); run_txn(r, 0, o);
        n_checks++; if (o.wr_n !== 0 || o.lat !== 2 || o.rd_n !== 1) begin
            n_fail++; $display("FAIL csrrsi_zero: got wr=%0d lat=%0d rd=%0d want 0 2 1", o.wr_n, o.lat, o.rd_n); end
        r = '{f3: 3'd5, idx: 12'h300, rs1: 5'd8, data: 32'h12345678, rd: 5'd0};
        model(r, e); run_txn(r, 0, o);
        n_checks++; if (o.rd_n !== 0 || o.wr_n !== 1 || o.wdata !== 32'h8) begin
            n_fail++; $display("FAIL csrrwi_x0: got rd=%0d wr=%0d wdata %h want 0 1 8", o.rd_n, o.wr_n, o.wdata); end
    endtask

    task automatic test_illegal();
        req_t r; obs_t o; exp_t e;
        r = '{f3: 3'd4, idx: 12'h340, rs1: 5'd3, data: 32'hA5A5A5A5, rd: 5'd6};
        model(r, e); run_txn(r, 0, o);
        n_checks++; if (o.rd_n !== 0 || o.wr_n !== 0 || o.illegal !== 1'b1 || o.rdata !== 32'h0) begin
            n_fail++; $display("FAIL illegal_f3: got rd=%0d wr=%0d ill=%b rdata %h want 0 0 1 0", o.rd_n, o.wr_n, o.illegal, o.rdata); end
        r = '{f3: 3'd1, idx: 12'hF11, rs1: 5'd3, data: 32'h55AA55AA, rd: 5'd6};
        model(r, e); run_txn(r, 0, o);
`ifdef CSR_RO_CHECK_EN
        n_checks++; if (o.illegal !== 1'b1 || o.wr_n !== 0 || o.rd_n !== 1) begin
            n_fail++; $display("FAIL ro_write: got ill=%b wr=%0d rd=%0d want 1 0 1", o.illegal, o.wr_n, o.rd_n); end
`else
        n_checks++; if (o.illegal !== 1'b0 || o.wr_n !== 1) begin
            n_fail++; $display("FAIL ro_write: got ill=%b wr=%0d want 0 1", o.illegal, o.wr_n); end
`endif
    endtask

    task automatic test_backpressure();
        req_t r; obs_t o; exp_t e;
        r = '{f3: 3'd2, idx: 12'h305, rs1: 5'd0, data: 32'h0, rd: 5'd17};
        model(r, e); run_txn(r, 4, o);
        n_checks++; if (!o.hold_ok) begin n_fail++; $display("FAIL backpressure_stable: got 0 want 1"); end
        n_checks++; if (o.rdata !== e.rdata || o.rd_idx !== 5'd17) begin
            n_fail++; $display("FAIL backpressure_rsp: got %h rd %0d want %h 17", o.rdata, o.rd_idx, e.rdata); end
    endtask

    task automatic test_random();
        req_t r; obs_t o; exp_t e;
        logic [11:0] pool [7];
        pool = '{12'h340, 12'h305, 12'h300, 12'h341, 12'hF11, 12'hC00, 12'h7C0};
        for (int t = 0; t < 60; t++) begin
            r.f3   = 3'($urandom_range(0, 7));
            r.idx  = pool[$urandom_range(0, 6)];
            r.rs1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            r.data = $urandom;
            r.rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            model(r, e);
            run_txn(r, $urandom_range(0, 2), o);
            n_checks++; if (o.rdata !== e.rdata || o.illegal !== e.illegal || o.rd_idx !== r.rd) begin
                n_fail++; $display("FAIL rand_rsp[%0d]: got %h ill=%b rd=%0d want %h ill=%b rd=%0d",
                                   t, o.rdata, o.illegal, o.rd_idx, e.rdata, e.illegal, r.rd); end
            n_checks++; if (o.lat !== e.lat || o.rd_n !== e.rd_n || o.wr_n !== e.wr_n || !o.hold_ok || !o.idle_after) begin
                n_fail++; $display("FAIL rand_seq[%0d]: got lat=%0d rd=%0d wr=%0d hold=%b idle=%b want %0d %0d %0d 1 1",
                                   t, o.lat, o.rd_n, o.wr_n, o.hold_ok, o.idle_after, e.lat, e.rd_n, e.wr_n); end
            if (e.wr_n == 1) begin
                n_checks++; if (o.wdata !== e.wdata || o.widx !== r.idx) begin
                    n_fail++; $display("FAIL rand_wdata[%0d]: got %h @%h want %h @%h", t, o.wdata, o.widx, e.wdata, r.idx); end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        req_t r; obs_t o; exp_t e;
        int wr0, n;
        wr0 = wr_cnt;
        bus.req_funct3 = 3'd1; bus.req_csr_idx = 12'h341; bus.req_rs1_idx = 5'd1;
        bus.req_rs1_data = 32'h12345678; bus.req_rd_idx = 5'd3; bus.req_valid = 1'b1;
        @(posedge clk_i); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (csr_wr_en !== 1'b1 && n < 6) begin @(posedge clk_i); #1; n++; end
        n_checks++; if (csr_wr_en !== 1'b1) begin n_fail++; $display("FAIL rst_reach_write: got wr_en %b want 1", csr_wr_en); end
        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++; if (wr_cnt - wr0 !== 0) begin n_fail++; $display("FAIL rst_no_write: got %0d writes want 0", wr_cnt - wr0); end
        n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_state: got ready %b rsp_valid %b want 1 0", bus.req_ready, bus.rsp_valid); end
        r = '{f3: 3'd2, idx: 12'h341, rs1: 5'd0, data: 32'h0, rd: 5'd4};
        model(r, e); run_txn(r, 0, o);
        n_checks++; if (o.rdata !== e.rdata || o.wr_n !== 0) begin
            n_fail++; $display("FAIL rst_csr_kept: got %h wr=%0d want %h 0", o.rdata, o.wr_n, e.rdata); end
    endtask

    initial begin
        rst_ni = 1'b0;
        clear_rf = 1'b1;
        bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_csr_idx = '0;
        bus.req_rs1_idx = '0; bus.req_rs1_data = '0; bus.req_rd_idx = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        test_reset();
        clear_rf = 1'b0;
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        test_reset();
        test_csrrw();
        test_set_clear();
        test_immediate();
        test_illegal();
        test_backpressure();
        test_random();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
